// File: rtl/bus_cs_sync_pkg.sv
// Shared types for the host bus front end.
// Holds the bus FSM encoding and the settle counter limit.
package xv;

    typedef enum logic [1:0] {
        BUS_IDLE,
        BUS_SETTLE,
        BUS_STROBE,
        BUS_HOLD
    } bus_state_t;

    localparam int BUS_SETTLE_MAX = 7;

endpackage

// File: rtl/bus_sync_ff.sv
// Generic multi-flop synchroniser with async reset.
// RST_VAL gives the per-bit value held while reset is asserted.
module bus_sync_ff #(
    parameter int               STAGES  = 2,
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    if (STAGES < 2 || STAGES > 3) begin : g_bad_stages
        $error("bus_sync_ff: STAGES must be 2..3");
    end

    logic [WIDTH-1:0] sync_q [STAGES];

    // Shift the asynchronous input through the flop chain
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < STAGES; i++) begin
                sync_q[i] <= RST_VAL;
            end
        end else begin
            sync_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/bus_cs_sync.sv
// Host bus pad front end: sync, CS settle qualify, one strobe per access.
// Optional BUS_CS_GLITCH_FILTER_EN: CS edges need two consecutive samples.
module bus_cs_sync
    import xv::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset_i,
    input  logic       pad_cs_n_i,
    input  logic       pad_rd_nwr_i,
    input  logic [3:0] pad_reg_num_i,
    input  logic       pad_bytesel_i,
    input  logic [7:0] pad_data_i,
    output logic [7:0] pad_data_o,
    output logic       pad_data_oe_o,
    output logic       bus_strobe_o,
    output logic       bus_rd_nwr_o,
    output logic [3:0] bus_reg_num_o,
    output logic       bus_bytesel_o,
    output logic [7:0] bus_data_o,
    input  logic [7:0] bus_data_i
);

    if (SETTLE_CYCLES < 0 || SETTLE_CYCLES > BUS_SETTLE_MAX) begin : g_bad_settle
        $error("bus_cs_sync: SETTLE_CYCLES must be 0..7");
    end

    localparam logic [2:0] SETTLE_LD = 3'(SETTLE_CYCLES);

    logic [14:0] pad_vec;
    logic [14:0] sync_vec;
    logic        cs_s;
    logic        rd_s;
    logic [3:0]  reg_num_s;
    logic        bytesel_s;
    logic [7:0]  data_s;

    assign pad_vec = {pad_cs_n_i, pad_rd_nwr_i, pad_reg_num_i,
                      pad_bytesel_i, pad_data_i};

    // cs_n resets to the inactive (high) level
    bus_sync_ff #(
        .STAGES (SYNC_STAGES),
        .WIDTH  (15),
        .RST_VAL(15'h4000)
    ) u_sync (
        .clk    (clk),
        .reset_i(reset_i),
        .d_i    (pad_vec),
        .q_o    (sync_vec)
    );

    assign {cs_s, rd_s, reg_num_s, bytesel_s, data_s} = sync_vec;

    logic cs_lo;
    logic cs_hi;

`ifdef BUS_CS_GLITCH_FILTER_EN
    logic cs_prev_q;

    // Previous synced CS sample for two-in-a-row decisions
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) cs_prev_q <= 1'b1;
        else         cs_prev_q <= cs_s;
    end

    assign cs_lo = ~cs_s & ~cs_prev_q;
    assign cs_hi =  cs_s &  cs_prev_q;
`else
    assign cs_lo = ~cs_s;
    assign cs_hi =  cs_s;
`endif

    bus_state_t state_q, state_d;
    logic [2:0] cnt_q, cnt_d;

    // State and settle counter registers
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            state_q <= BUS_IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: qualify CS, strobe once, wait for release
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            BUS_IDLE: begin
                if (cs_lo) begin
                    if (SETTLE_CYCLES == 0) begin
                        state_d = BUS_STROBE;
                    end else begin
                        state_d = BUS_SETTLE;
                        cnt_d   = SETTLE_LD;
                    end
                end
            end
            BUS_SETTLE: begin
                if (cs_s)               state_d = BUS_IDLE;
                else if (cnt_q == 3'd1) state_d = BUS_STROBE;
                else                    cnt_d   = cnt_q - 3'd1;
            end
            BUS_STROBE: state_d = BUS_HOLD;
            BUS_HOLD: begin
                if (cs_hi) state_d = BUS_IDLE;
            end
            default: state_d = BUS_IDLE;
        endcase
    end

    logic       rd_q;
    logic [3:0] reg_num_q;
    logic       bytesel_q;
    logic [7:0] data_q;
    logic [7:0] pad_data_q;

    // Capture access fields so they are valid together with the strobe
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            rd_q      <= 1'b0;
            reg_num_q <= 4'd0;
            bytesel_q <= 1'b0;
            data_q    <= 8'd0;
        end else if (state_d == BUS_STROBE) begin
            rd_q      <= rd_s;
            reg_num_q <= reg_num_s;
            bytesel_q <= bytesel_s;
            data_q    <= data_s;
        end
    end

    // Track read data while holding; freeze once the access ends
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i)                  pad_data_q <= 8'd0;
        else if (state_q == BUS_HOLD) pad_data_q <= bus_data_i;
    end

    // Outputs decoded from the current state
    always_comb begin
        bus_strobe_o  = (state_q == BUS_STROBE);
        pad_data_oe_o = (state_q == BUS_HOLD) & rd_q;
    end

    assign bus_rd_nwr_o  = rd_q;
    assign bus_reg_num_o = reg_num_q;
    assign bus_bytesel_o = bytesel_q;
    assign bus_data_o    = data_q;
    assign pad_data_o    = pad_data_q;

endmodule
